temp_hyst_monitor: RTL and testbench

- Multi-channel successor to the single-channel temperature hysteresis FSM. Compares N averaged temperature samples against shared high/low thresholds.
- Adds per-channel debounce (persistence count), signed/unsigned compare, sticky alarm latches with per-channel clear, rise pulses, an aggregate warning and threshold-misconfiguration detection.
- Sits between the temperature averaging stage and the alarm/interrupt logic.

---
 rtl/temp_mon_pkg.sv | 36 +++
 rtl/hyst_channel.sv | 120 ++++++++++++
 rtl/temp_hyst_monitor.sv | 79 +++++++
 tb/tb_temp_hyst_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/temp_mon_pkg.sv
// Shared definitions for the multi-channel temperature hysteresis monitor.
//   state_t   : per-channel FSM state encoding (also used as debug visibility)
//   temp_lt   : width-generic signed/unsigned "a < b" compare
package temp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_WARN      = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

  // Widest operand temp_lt accepts. Callers zero-extend their TEMP_W-bit
  // operands into this width.
  localparam int unsigned CMP_MAX_W = 64;

  // Returns a < b for operands that are w bits wide.
  // Two's-complement order is mapped onto unsigned order by inverting the
  // sign bit of both operands. Once that is done, one unsigned compare
  // covers both modes.
  function automatic logic temp_lt(
    input logic [CMP_MAX_W-1:0] a,
    input logic [CMP_MAX_W-1:0] b,
    input int unsigned          w,
    input logic                 signed_mode
  );
    logic [CMP_MAX_W-1:0] ka;
    logic [CMP_MAX_W-1:0] kb;
    ka = a;
    kb = b;
    ka[w-1] = ka[w-1] ^ signed_mode;
    kb[w-1] = kb[w-1] ^ signed_mode;
    return (ka < kb);
  endfunction

endpackage

// File: rtl/hyst_channel.sv
// One temperature channel: hysteresis FSM with a persistence counter, the
// rise pulse and the sticky warning latch.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   acc          : sample accepted this cycle (valid and configuration sane)
//   above, below : sample > high threshold, sample < low threshold
//   sticky_clr   : clears warn_sticky (a simultaneous set wins)
//   state        : registered FSM state; temp_warn is decoded from it
//   warn_rise    : one-cycle pulse on the first cycle in WARN
//   warn_sticky  : latched warning history
//
// Handshake: the channel has no back-pressure. A sample counts only on a
// cycle where acc is high. On any other cycle the FSM and the counter hold.
module hyst_channel
  import temp_mon_pkg::*;
#(
  parameter int unsigned PERSIST = 3,
  parameter int unsigned CNT_W   = $clog2(PERSIST + 1)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   acc,
  input  logic   above,
  input  logic   below,
  input  logic   sticky_clr,
  output state_t state,
  output logic   warn_rise,
  output logic   warn_sticky
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             enter_warn;

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (acc) begin
      unique case (state)
        ST_IDLE: begin
          if (above) begin
            if (PERSIST == 1) begin
              state_n = ST_WARN;
            end else begin
              state_n = ST_ARMING;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_ARMING: begin
          if (above) begin
            if (cnt_inc == CNT_FULL) begin
              state_n = ST_WARN;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_WARN: begin
          if (below) begin
            if (PERSIST == 1) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_RELEASING;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_RELEASING: begin
          if (below) begin
            if (cnt_inc == CNT_FULL) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_WARN;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Only a fresh entry counts as a warning event. Returning from RELEASING
  // means the channel never left the warning condition.
  assign enter_warn = (state_n == ST_WARN) &&
                      ((state == ST_IDLE) || (state == ST_ARMING));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      warn_rise   <= 1'b0;
      warn_sticky <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      warn_rise   <= enter_warn;
      warn_sticky <= enter_warn | (warn_sticky & ~sticky_clr);
    end
  end

endmodule

// File: rtl/temp_hyst_monitor.sv
// Multi-channel temperature hysteresis monitor. It compares N_CH averaged
// samples against shared high/low thresholds, and each channel confirms a
// crossing only after PERSIST consecutive accepted samples.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sample_valid  : temp_average carries a new sample set this cycle
//   temp_average  : packed samples, channel i at [i*TEMP_W +: TEMP_W]
//   temp_high     : arm threshold (sample > temp_high)
//   temp_low      : release threshold (sample < temp_low)
//   sticky_clr    : per-channel clear of warn_sticky
//   temp_warn     : per-channel confirmed warning (WARN or RELEASING)
//   warn_rise     : per-channel one-cycle pulse on entering WARN
//   warn_sticky   : per-channel latched warning history
//   warn_any      : OR of temp_warn
//   cfg_error     : temp_low > temp_high (combinational); freezes all channels
module temp_hyst_monitor
  import temp_mon_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TEMP_W     = 16,
  parameter int unsigned PERSIST    = 3,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [N_CH*TEMP_W-1:0] temp_average,
  input  logic [TEMP_W-1:0]      temp_high,
  input  logic [TEMP_W-1:0]      temp_low,
  input  logic [N_CH-1:0]        sticky_clr,
  output logic [N_CH-1:0]        temp_warn,
  output logic [N_CH-1:0]        warn_rise,
  output logic [N_CH-1:0]        warn_sticky,
  output logic                   warn_any,
  output logic                   cfg_error
);

  logic acc;

  // Per-channel FSM state, kept visible for checkers.
  state_t ch_state [N_CH];

  // With temp_low == temp_high the band is one value wide, and that is legal.
  // Only a strictly inverted pair is an error.
  assign cfg_error = temp_lt(CMP_MAX_W'(temp_high), CMP_MAX_W'(temp_low),
                             TEMP_W, SIGNED_CMP);
  assign acc       = sample_valid & ~cfg_error;
  assign warn_any  = |temp_warn;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [TEMP_W-1:0] sample;
    logic              above;
    logic              below;

    assign sample = temp_average[i*TEMP_W +: TEMP_W];
    assign above  = temp_lt(CMP_MAX_W'(temp_high), CMP_MAX_W'(sample),
                            TEMP_W, SIGNED_CMP);
    assign below  = temp_lt(CMP_MAX_W'(sample), CMP_MAX_W'(temp_low),
                            TEMP_W, SIGNED_CMP);

    hyst_channel #(
      .PERSIST (PERSIST)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .acc         (acc),
      .above       (above),
      .below       (below),
      .sticky_clr  (sticky_clr[i]),
      .state       (ch_state[i]),
      .warn_rise   (warn_rise[i]),
      .warn_sticky (warn_sticky[i])
    );

    assign temp_warn[i] = (ch_state[i] == ST_WARN) ||
                          (ch_state[i] == ST_RELEASING);
  end

endmodule

// File: tb/tb_temp_hyst_monitor.sv
// Directed bench for temp_hyst_monitor. One unsigned instance and one signed
// instance share all inputs. PERSIST=3, N_CH=4, TEMP_W=16.
module tb_temp_hyst_monitor;

  localparam int N_CH   = 4;
  localparam int TEMP_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sample_valid;
  logic [N_CH*TEMP_W-1:0] temp_average;
  logic [TEMP_W-1:0]      temp_high;
  logic [TEMP_W-1:0]      temp_low;
  logic [N_CH-1:0]        sticky_clr;

  logic [N_CH-1:0] temp_warn, warn_rise, warn_sticky;
  logic            warn_any, cfg_error;
  logic [N_CH-1:0] temp_warn_s, warn_rise_s, warn_sticky_s;
  logic            warn_any_s, cfg_error_s;

  logic [TEMP_W-1:0] fill;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  temp_hyst_monitor #(.N_CH(N_CH), .TEMP_W(TEMP_W), .PERSIST(3), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .temp_average(temp_average),
    .temp_high(temp_high), .temp_low(temp_low), .sticky_clr(sticky_clr),
    .temp_warn(temp_warn), .warn_rise(warn_rise), .warn_sticky(warn_sticky),
    .warn_any(warn_any), .cfg_error(cfg_error)
  );

  temp_hyst_monitor #(.N_CH(N_CH), .TEMP_W(TEMP_W), .PERSIST(3), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .temp_average(temp_average),
    .temp_high(temp_high), .temp_low(temp_low), .sticky_clr(sticky_clr),
    .temp_warn(temp_warn_s), .warn_rise(warn_rise_s), .warn_sticky(warn_sticky_s),
    .warn_any(warn_any_s), .cfg_error(cfg_error_s)
  );

  // ---------------- driver tasks ----------------
  // Accepted sample on channel ch; every other channel carries 'fill'.
  task automatic send(input int ch, input logic [TEMP_W-1:0] v);
    for (int i = 0; i < N_CH; i++)
      temp_average[i*TEMP_W +: TEMP_W] = (i == ch) ? v : fill;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sticky_clr   = '0;
  endtask

  task automatic idle();
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    sticky_clr = '0;
  endtask

  task automatic pulse_reset();
    sample_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; sample_valid = 1'b0; temp_average = '0;
    temp_high = 16'd100; temp_low = 16'd80; sticky_clr = '0; fill = 16'd90;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_warn",   32'(temp_warn),   32'h0);
    chk("rst_rise",   32'(warn_rise),   32'h0);
    chk("rst_sticky", 32'(warn_sticky), 32'h0);
    chk("rst_any",    32'(warn_any),    32'h0);
    chk("rst_cfg",    32'(cfg_error),   32'h0);

    // A non-qualifying sample breaks the consecutive run.
    send(0, 101); send(0, 101); send(0, 99); send(0, 101); send(0, 101);
    chk("break_warn", 32'(temp_warn), 32'h0);
    send(0, 90);

    // A non-valid gap does not break the run.
    send(0, 101); idle(); send(0, 101);
    chk("arm2_warn", 32'(temp_warn), 32'h0);
    send(0, 101);
    chk("arm3_warn",   32'(temp_warn),   32'h1);
    chk("arm3_rise",   32'(warn_rise),   32'h1);
    chk("arm3_sticky", 32'(warn_sticky), 32'h1);
    chk("arm3_any",    32'(warn_any),    32'h1);
    idle();
    chk("rise_1cyc", 32'(warn_rise), 32'h0);
    chk("warn_hold", 32'(temp_warn), 32'h1);

    // A sample equal to temp_low never releases.
    send(0, 80);
    chk("eq_low_warn", 32'(temp_warn), 32'h1);

    // Release with an interruption, then a complete release.
    send(0, 79); send(0, 79);
    chk("rel2_warn", 32'(temp_warn), 32'h1);
    send(0, 85);
    chk("reentry_warn", 32'(temp_warn), 32'h1);
    chk("reentry_rise", 32'(warn_rise), 32'h0);
    send(0, 79); send(0, 79);
    chk("rel_b2_warn", 32'(temp_warn), 32'h1);
    send(0, 79);
    chk("rel_done_warn", 32'(temp_warn),   32'h0);
    chk("rel_sticky",    32'(warn_sticky), 32'h1);
    chk("rel_any",       32'(warn_any),    32'h0);

    // When a set and a clear arrive together, the set wins. A lone clear then clears.
    send(0, 101); send(0, 101);
    sticky_clr = 4'b0001;
    send(0, 101);
    chk("setclr_sticky", 32'(warn_sticky), 32'h1);
    chk("setclr_rise",   32'(warn_rise),   32'h1);
    sticky_clr = 4'b0001;
    idle();
    chk("clr_sticky", 32'(warn_sticky), 32'h0);
    chk("clr_warn",   32'(temp_warn),   32'h1);
    send(0, 70); send(0, 70); send(0, 70);
    chk("ch0_idle", 32'(temp_warn), 32'h0);

    // A sample equal to temp_high never arms.
    send(1, 100); send(1, 100); send(1, 100);
    chk("eq_high_warn", 32'(temp_warn), 32'h0);

    // A misconfiguration freezes the counters mid-count.
    send(3, 101); send(3, 101);
    temp_low = 16'd120;
    #1;
    chk("cfg_err", 32'(cfg_error), 32'h1);
    for (int k = 0; k < 5; k++) send(1, 200);
    chk("cfg_frozen_warn", 32'(temp_warn), 32'h0);
    temp_low = 16'd80;
    #1;
    chk("cfg_clear", 32'(cfg_error), 32'h0);
    send(3, 101);
    chk("freeze_resume", 32'(temp_warn), 32'h8);
    send(1, 200); send(1, 200);
    chk("ch1_arm2", 32'(temp_warn), 32'h8);
    send(1, 200);
    chk("ch1_warn",   32'(temp_warn),   32'ha);
    chk("ch1_sticky", 32'(warn_sticky), 32'ha);

    // Reset while channels are warning.
    pulse_reset();
    chk("rst2_warn",   32'(temp_warn),   32'h0);
    chk("rst2_sticky", 32'(warn_sticky), 32'h0);
    chk("rst2_any",    32'(warn_any),    32'h0);

    // Reset during ARMING restarts the count.
    send(3, 101); send(3, 101);
    pulse_reset();
    chk("rst_arm_warn", 32'(temp_warn), 32'h0);
    send(3, 101); send(3, 101);
    chk("restart2_warn", 32'(temp_warn), 32'h0);
    send(3, 101);
    chk("restart3_warn", 32'(temp_warn), 32'h8);
    chk("restart3_rise", 32'(warn_rise), 32'h8);

    // Reset during RELEASING.
    send(3, 79);
    chk("releasing_warn", 32'(temp_warn), 32'h8);
    pulse_reset();
    chk("rst_rel_warn", 32'(temp_warn), 32'h0);

    // Signed compare: high = -10, low = -20.
    temp_high = 16'hFFF6; temp_low = 16'hFFEC;
    #1;
    chk("s_cfg",  32'(cfg_error_s), 32'h0);
    send(2, 16'hFFFB); send(2, 16'hFFFB);
    chk("s_arm2", 32'(temp_warn_s[2]), 32'h0);
    send(2, 16'hFFFB);
    chk("s_warn", 32'(temp_warn_s[2]), 32'h1);
    send(2, 16'hFFE7); send(2, 16'hFFE7);
    chk("s_rel2", 32'(temp_warn_s[2]), 32'h1);
    send(2, 16'hFFE7);
    chk("s_rel3", 32'(temp_warn_s[2]), 32'h0);

    // +5 is above -10 when signed but below 0xFFF6 when unsigned.
    pulse_reset();
    send(2, 16'd5); send(2, 16'd5); send(2, 16'd5);
    chk("s_pos_warn", 32'(temp_warn_s[2]), 32'h1);
    chk("u_pos_warn", 32'(temp_warn[2]),   32'h0);
    temp_low = 16'd5;
    #1;
    chk("s_cfg_err", 32'(cfg_error_s), 32'h1);
    chk("u_cfg_ok",  32'(cfg_error),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
